demux_deserializer: RTL and testbench

DEMUX_DESERIALIZER -- requirements
Module: demux_deserializer

---
 rtl/demux_deserializer.sv | 96 +++++++++
 tb/tb_demux_deserializer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/demux_deserializer.sv
// Collects a serial bitstream into W-bit frames after sync; data_out updates on the edge the last bit lands (zero latency).
// Newest frame overwrites an unconsumed one; optional sticky overflow port under DEMUX_DESERIALIZER_OVERFLOW_EN.
module demux_deserializer #(
  parameter string ARCHITECTURE = "BEHAVIORAL",
  parameter int    SELECT_LINES = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         data_in,
  input  logic                         data_valid,
  input  logic                         sync,
  input  logic                         out_ready,
  output logic [(2**SELECT_LINES)-1:0] data_out,
  output logic                         data_out_valid,
  output logic [SELECT_LINES-1:0]      frame_ptr,
  output logic                         locked
`ifdef DEMUX_DESERIALIZER_OVERFLOW_EN
  ,
  output logic                         overflow
`endif
);

  localparam int W = 2**SELECT_LINES;
  localparam logic [SELECT_LINES-1:0] LAST_IDX = SELECT_LINES'(W - 1);

  // Vendor variants share the behavioural datapath; anything else is a configuration error.
  if (!(ARCHITECTURE == "BEHAVIORAL" || ARCHITECTURE == "VIRTEX5" || ARCHITECTURE == "VIRTEX6")) begin : g_bad_arch
    $error("demux_deserializer: unsupported ARCHITECTURE");
  end
  if (SELECT_LINES < 1 || SELECT_LINES > 8) begin : g_bad_width
    $error("demux_deserializer: SELECT_LINES must be 1..8");
  end

  typedef enum logic {WAIT_SYNC = 1'b0, COLLECT = 1'b1} state_t;

  state_t                  state, state_nxt;
  logic [W-1:0]            shadow, shadow_nxt;
  logic [W-1:0]            data_out_nxt;
  logic                    data_out_valid_nxt;
  logic [SELECT_LINES-1:0] frame_ptr_nxt;
  logic                    frame_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= WAIT_SYNC;
      shadow         <= '0;
      data_out       <= '0;
      data_out_valid <= 1'b0;
      frame_ptr      <= '0;
    end else begin
      state          <= state_nxt;
      shadow         <= shadow_nxt;
      data_out       <= data_out_nxt;
      data_out_valid <= data_out_valid_nxt;
      frame_ptr      <= frame_ptr_nxt;
    end
  end

  always_comb begin
    state_nxt          = state;
    shadow_nxt         = shadow;
    frame_ptr_nxt      = frame_ptr;
    data_out_nxt       = data_out;
    data_out_valid_nxt = data_out_valid & ~out_ready;
    frame_done         = 1'b0;
    if (data_valid) begin
      if (sync) begin
        // A sync always restarts framing, discarding any partial frame.
        shadow_nxt[0] = data_in;
        frame_ptr_nxt = SELECT_LINES'(1);
        state_nxt     = COLLECT;
      end else if (state == COLLECT) begin
        shadow_nxt[frame_ptr] = data_in;
        frame_ptr_nxt         = frame_ptr + 1'b1;
        if (frame_ptr == LAST_IDX) begin
          frame_done         = 1'b1;
          data_out_nxt       = shadow_nxt;
          data_out_valid_nxt = 1'b1;
        end
      end
    end
  end

  assign locked = (state == COLLECT);

`ifdef DEMUX_DESERIALIZER_OVERFLOW_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (frame_done && data_out_valid && !out_ready) begin
      overflow <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_demux_deserializer.sv
// Randomised and directed bench for demux_deserializer at SELECT_LINES=2 (W=4) with a queue-based frame model.
module tb_demux_deserializer;

  localparam int SL = 2;
  localparam int W  = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          data_in = 1'b0;
  logic          data_valid = 1'b0;
  logic          sync = 1'b0;
  logic          out_ready = 1'b0;
  logic [W-1:0]  data_out;
  logic          data_out_valid;
  logic [SL-1:0] frame_ptr;
  logic          locked;
`ifdef DEMUX_DESERIALIZER_OVERFLOW_EN
  logic          overflow;
`endif

  int n_vec = 0;
  int n_err = 0;

  // Reference model: bits received since the last sync, plus output-side state.
  bit           q[$];
  bit           m_locked = 1'b0;
  bit           m_vld = 1'b0;
  bit           m_ovf = 1'b0;
  logic [W-1:0] m_out = '0;

  demux_deserializer #(
    .ARCHITECTURE("BEHAVIORAL"),
    .SELECT_LINES(SL)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .data_in       (data_in),
    .data_valid    (data_valid),
    .sync          (sync),
    .out_ready     (out_ready),
    .data_out      (data_out),
    .data_out_valid(data_out_valid),
    .frame_ptr     (frame_ptr),
    .locked        (locked)
`ifdef DEMUX_DESERIALIZER_OVERFLOW_EN
    ,
    .overflow      (overflow)
`endif
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    q.delete();
    m_locked = 1'b0;
    m_vld    = 1'b0;
    m_ovf    = 1'b0;
    m_out    = '0;
  endtask

  task automatic model_edge(input bit v, input bit s, input bit d, input bit r);
    bit           done;
    logic [W-1:0] val;
    done = 1'b0;
    val  = '0;
    if (v) begin
      if (s) begin
        q.delete();
        q.push_back(d);
        m_locked = 1'b1;
      end else if (m_locked) begin
        q.push_back(d);
        if (q.size() == W) begin
          done = 1'b1;
          for (int k = 0; k < W; k++) val = val | (W'(q[k]) << k);
          q.delete();
        end
      end
    end
    if (done) begin
      if (m_vld && !r) m_ovf = 1'b1;
      m_out = val;
      m_vld = 1'b1;
    end else if (r) begin
      m_vld = 1'b0;
    end
  endtask

  // Drive one cycle of inputs, let the edge happen, advance the model, settle past the edge.
  task automatic step(input bit v, input bit s, input bit d, input bit r);
    data_valid = v;
    sync       = s;
    data_in    = d;
    out_ready  = r;
    @(posedge clk);
    model_edge(v, s, d, r);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n      = 1'b0;
    data_valid = 1'b0;
    sync       = 1'b0;
    data_in    = 1'b0;
    out_ready  = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #3;
    model_reset();
    n_vec++; if (data_out !== 4'h0) begin n_err++; $display("FAIL reset data_out: got %h want 0", data_out); end
    n_vec++; if (data_out_valid !== 1'b0) begin n_err++; $display("FAIL reset data_out_valid: got %b want 0", data_out_valid); end
    n_vec++; if (frame_ptr !== 2'd0) begin n_err++; $display("FAIL reset frame_ptr: got %0d want 0", frame_ptr); end
    n_vec++; if (locked !== 1'b0) begin n_err++; $display("FAIL reset locked: got %b want 0", locked); end
`ifdef DEMUX_DESERIALIZER_OVERFLOW_EN
    n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset overflow: got %b want 0", overflow); end
`endif
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_no_sync();
    for (int i = 0; i < 4; i++) step(1, 0, 1, 1);
    n_vec++; if (locked !== 1'b0) begin n_err++; $display("FAIL nosync locked: got %b want 0", locked); end
    n_vec++; if (data_out_valid !== 1'b0) begin n_err++; $display("FAIL nosync data_out_valid: got %b want 0", data_out_valid); end
    n_vec++; if (data_out !== 4'h0) begin n_err++; $display("FAIL nosync data_out: got %h want 0", data_out); end
    n_vec++; if (frame_ptr !== 2'd0) begin n_err++; $display("FAIL nosync frame_ptr: got %0d want 0", frame_ptr); end
  endtask

  task automatic test_basic_frame();
    step(1, 1, 1, 1);
    n_vec++; if (locked !== 1'b1) begin n_err++; $display("FAIL basic locked: got %b want 1", locked); end
    n_vec++; if (frame_ptr !== 2'd1) begin n_err++; $display("FAIL basic frame_ptr after sync: got %0d want 1", frame_ptr); end
    step(1, 0, 0, 1);
    step(1, 0, 1, 1);
    n_vec++; if (data_out_valid !== 1'b0) begin n_err++; $display("FAIL basic early valid: got %b want 0", data_out_valid); end
    step(1, 0, 1, 1);
    n_vec++; if (data_out !== 4'b1101) begin n_err++; $display("FAIL basic data_out: got %b want 1101", data_out); end
    n_vec++; if (data_out_valid !== 1'b1) begin n_err++; $display("FAIL basic data_out_valid: got %b want 1", data_out_valid); end
    n_vec++; if (frame_ptr !== 2'd0) begin n_err++; $display("FAIL basic frame_ptr wrap: got %0d want 0", frame_ptr); end
    step(0, 0, 0, 1);
    n_vec++; if (data_out_valid !== 1'b0) begin n_err++; $display("FAIL basic valid clear: got %b want 0", data_out_valid); end
    n_vec++; if (locked !== 1'b1) begin n_err++; $display("FAIL basic stays locked: got %b want 1", locked); end
  endtask

  task automatic test_resync_abort();
    step(1, 1, 1, 1);
    step(1, 0, 1, 1);
    n_vec++; if (frame_ptr !== 2'd2) begin n_err++; $display("FAIL resync frame_ptr: got %0d want 2", frame_ptr); end
    step(1, 1, 0, 1);
    n_vec++; if (frame_ptr !== 2'd1) begin n_err++; $display("FAIL resync restart ptr: got %0d want 1", frame_ptr); end
    step(1, 0, 1, 1);
    step(1, 0, 0, 1);
    n_vec++; if (data_out_valid !== 1'b0) begin n_err++; $display("FAIL resync aborted output: got %b want 0", data_out_valid); end
    step(1, 0, 0, 1);
    n_vec++; if (data_out !== 4'b0010) begin n_err++; $display("FAIL resync data_out: got %b want 0010", data_out); end
    n_vec++; if (data_out_valid !== 1'b1) begin n_err++; $display("FAIL resync data_out_valid: got %b want 1", data_out_valid); end
    step(0, 0, 0, 1);
  endtask

  task automatic test_same_edge_handshake();
    step(1, 0, 1, 0);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 1, 0);
    n_vec++; if (data_out !== 4'h9) begin n_err++; $display("FAIL handshake first frame: got %h want 9", data_out); end
    step(1, 0, 0, 0);
    step(1, 0, 1, 0);
    step(1, 0, 1, 0);
    n_vec++; if (data_out_valid !== 1'b1) begin n_err++; $display("FAIL handshake held valid: got %b want 1", data_out_valid); end
    step(1, 0, 0, 1);
    n_vec++; if (data_out !== 4'h6) begin n_err++; $display("FAIL handshake data_out: got %h want 6", data_out); end
    n_vec++; if (data_out_valid !== 1'b1) begin n_err++; $display("FAIL handshake data_out_valid: got %b want 1", data_out_valid); end
`ifdef DEMUX_DESERIALIZER_OVERFLOW_EN
    n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL handshake overflow: got %b want 0", overflow); end
`endif
    step(0, 0, 0, 1);
    n_vec++; if (data_out_valid !== 1'b0) begin n_err++; $display("FAIL handshake consumed: got %b want 0", data_out_valid); end
  endtask

  task automatic test_overflow();
    logic [7:0] bits;
    bits = 8'h5A;
    for (int i = 0; i < 8; i++) begin
      step(1, 0, bits[i], 0);
      if (i == 3) begin
        n_vec++; if (data_out !== 4'hA) begin n_err++; $display("FAIL overflow first frame: got %h want a", data_out); end
      end
    end
    n_vec++; if (data_out !== 4'h5) begin n_err++; $display("FAIL overflow newest: got %h want 5", data_out); end
    n_vec++; if (data_out_valid !== 1'b1) begin n_err++; $display("FAIL overflow valid: got %b want 1", data_out_valid); end
`ifdef DEMUX_DESERIALIZER_OVERFLOW_EN
    n_vec++; if (overflow !== 1'b1) begin n_err++; $display("FAIL overflow flag: got %b want 1", overflow); end
    step(0, 0, 0, 1);
    n_vec++; if (overflow !== 1'b1) begin n_err++; $display("FAIL overflow sticky: got %b want 1", overflow); end
`endif
  endtask

  task automatic test_reset_midframe();
    step(1, 1, 1, 0);
    step(1, 0, 1, 0);
    step(1, 0, 1, 0);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    n_vec++; if (data_out !== 4'h0) begin n_err++; $display("FAIL midreset data_out: got %h want 0", data_out); end
    n_vec++; if (data_out_valid !== 1'b0) begin n_err++; $display("FAIL midreset valid: got %b want 0", data_out_valid); end
    n_vec++; if (frame_ptr !== 2'd0) begin n_err++; $display("FAIL midreset frame_ptr: got %0d want 0", frame_ptr); end
    n_vec++; if (locked !== 1'b0) begin n_err++; $display("FAIL midreset locked: got %b want 0", locked); end
`ifdef DEMUX_DESERIALIZER_OVERFLOW_EN
    n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL midreset overflow: got %b want 0", overflow); end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) step(1, 0, 1, 0);
    n_vec++; if (data_out_valid !== 1'b0) begin n_err++; $display("FAIL midreset no output: got %b want 0", data_out_valid); end
    n_vec++; if (locked !== 1'b0) begin n_err++; $display("FAIL midreset needs sync: got %b want 0", locked); end
    n_vec++; if (data_out !== 4'h0) begin n_err++; $display("FAIL midreset data_out after: got %h want 0", data_out); end
  endtask

  task automatic test_random();
    bit v, s, d, r;
    apply_reset();
    for (int i = 0; i < 800; i++) begin
      v = ($urandom_range(0, 3) != 0);
      s = ($urandom_range(0, 11) == 0);
      d = 1'($urandom);
      r = ($urandom_range(0, 2) != 0);
      step(v, s, d, r);
      n_vec++; if (data_out !== m_out) begin n_err++; $display("FAIL random data_out cyc %0d: got %h want %h", i, data_out, m_out); end
      n_vec++; if (data_out_valid !== m_vld) begin n_err++; $display("FAIL random valid cyc %0d: got %b want %b", i, data_out_valid, m_vld); end
      n_vec++; if (frame_ptr !== SL'(q.size())) begin n_err++; $display("FAIL random frame_ptr cyc %0d: got %0d want %0d", i, frame_ptr, q.size()); end
      n_vec++; if (locked !== m_locked) begin n_err++; $display("FAIL random locked cyc %0d: got %b want %b", i, locked, m_locked); end
`ifdef DEMUX_DESERIALIZER_OVERFLOW_EN
      n_vec++; if (overflow !== m_ovf) begin n_err++; $display("FAIL random overflow cyc %0d: got %b want %b", i, overflow, m_ovf); end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_no_sync();
    test_basic_frame();
    test_resync_abort();
    test_same_edge_handshake();
    test_overflow();
    test_reset_midframe();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
